// File: rtl/imm_encoder.sv
// imm_encoder: packs RV32I instruction fields and a decoder-style immediate
// into a 32-bit instruction word. Encoded words stream out with
// auto-incrementing byte addresses toward an instruction-memory write port.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid / in_ready   field-bundle handshake
//   fmt                   0=R 1=I 2=S 3=B 4=U 5=J, 6/7 reserved (rejected)
//   opcode, funct3, funct7, rd, rs1, rs2, imm   instruction fields
//   addr_load, addr_in    reload the address counter (wins over increment)
//   out_valid / out_ready encoded-word handshake
//   out_addr, out_word    byte address and encoded instruction
//   err_flag, err_count   sticky error flag, saturating rejected-bundle count
//
// Build option: define IMM_RANGE_CHECK_EN to reject bundles whose immediate
// cannot be represented in the selected format. Without it, out-of-range
// immediate bits are silently truncated and only reserved fmt values are
// rejected.
module imm_encoder #(
  parameter int              D_WIDTH    = 32,
  parameter int              A_WIDTH    = 32,
  parameter logic [A_WIDTH-1:0] RESET_ADDR = A_WIDTH'(32'hBFC0_0000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         fmt,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [D_WIDTH-1:0] imm,
  input  logic               addr_load,
  input  logic [A_WIDTH-1:0] addr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_WIDTH-1:0] out_addr,
  output logic [D_WIDTH-1:0] out_word,
  output logic               err_flag,
  output logic [7:0]         err_count
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  function automatic logic [31:0] encode(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [31:0] im
  );
    logic [31:0] w;
    w = 32'd0;
    case (f)
      FMT_R:   w = {f7, s2, s1, f3, d, op};
      FMT_I:   w = {im[11:0], s1, f3, d, op};
      FMT_S:   w = {im[11:5], s2, s1, f3, im[4:0], op};
      FMT_B:   w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
      FMT_U:   w = {im[31:12], d, op};
      FMT_J:   w = {im[20], im[10:1], im[11], im[19:12], d, op};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

`ifdef IMM_RANGE_CHECK_EN
  // True when the immediate survives the round trip through the format's
  // bit fields, i.e. the decoder would sign-extend it back unchanged.
  function automatic logic imm_in_range(input logic [2:0] f, input logic [31:0] im);
    logic ok;
    ok = 1'b1;
    case (f)
      FMT_I, FMT_S: ok = (&im[31:11]) || !(|im[31:11]);
      FMT_B:        ok = !im[0] && ((&im[31:12]) || !(|im[31:12]));
      FMT_J:        ok = !im[0] && ((&im[31:20]) || !(|im[31:20]));
      FMT_U:        ok = (im[11:0] == 12'd0);
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic               out_valid_q, out_valid_d;
  logic [D_WIDTH-1:0] out_word_q,  out_word_d;
  logic [A_WIDTH-1:0] out_addr_q,  out_addr_d;
  logic [A_WIDTH-1:0] next_addr_q, next_addr_d;
  logic               err_flag_q,  err_flag_d;
  logic [7:0]         err_count_q, err_count_d;

  logic accept;
  logic bad;
  logic emit;
  logic range_ok;
  logic [A_WIDTH-1:0] tag_addr;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef IMM_RANGE_CHECK_EN
  assign range_ok = imm_in_range(fmt, imm);
`else
  assign range_ok = 1'b1;
`endif

  assign bad  = accept && ((fmt > FMT_J) || !range_ok);
  assign emit = accept && !bad;

  // next_addr_q is the address the next emitted word receives. Allocating it
  // at acceptance is equivalent to advancing on the output handshake because
  // every emitted word is eventually handshaken (or wiped by reset, which
  // also resets the counter), and it keeps back-to-back words distinct.
  assign tag_addr = addr_load ? addr_in : next_addr_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_addr_d  = out_addr_q;
    next_addr_d = tag_addr;
    err_flag_d  = err_flag_q || bad;
    err_count_d = bad ? sat_inc8(err_count_q) : err_count_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (emit) begin
      out_valid_d = 1'b1;
      out_word_d  = D_WIDTH'(encode(fmt, opcode, funct3, funct7, rd, rs1, rs2, 32'(imm)));
      out_addr_d  = tag_addr;
      next_addr_d = tag_addr + A_WIDTH'(4);
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= RESET_ADDR;
      next_addr_q <= RESET_ADDR;
      err_flag_q  <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      next_addr_q <= next_addr_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_addr  = out_addr_q;
  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        addr_load;
  logic [31:0] addr_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_word;
  logic        err_flag;
  logic [7:0]  err_count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] err_base;

  imm_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .addr_load(addr_load), .addr_in(addr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_word(out_word),
    .err_flag(err_flag), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_word !== 32'h0) begin n_fail++; $display("FAIL reset_word: got %h want 00000000", out_word); end
    n_cmp++; if (out_addr !== 32'hBFC00000) begin n_fail++; $display("FAIL reset_addr: got %h want bfc00000", out_addr); end
    n_cmp++; if (err_flag !== 1'b0 || err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %b/%h want 0/00", err_flag, err_count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_i_then_r();
    out_ready = 1'b1;
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_word !== 32'h00500093) begin n_fail++; $display("FAIL i_word: got %b/%h want 1/00500093", out_valid, out_word); end
    n_cmp++; if (out_addr !== 32'hBFC00000) begin n_fail++; $display("FAIL i_addr: got %h want bfc00000", out_addr); end
    // sub x3, x1, x2 accepted in the same cycle the I word drains
    drive(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF);
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_word !== 32'h402081B3) begin n_fail++; $display("FAIL r_word: got %b/%h want 1/402081b3", out_valid, out_word); end
    n_cmp++; if (out_addr !== 32'hBFC00004) begin n_fail++; $display("FAIL r_addr: got %h want bfc00004", out_addr); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_b_j();
    drive(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
    tick();
    n_cmp++; if (out_word !== 32'hFE000EE3 || out_addr !== 32'hBFC00008) begin n_fail++; $display("FAIL b_word: got %h@%h want fe000ee3@bfc00008", out_word, out_addr); end
    drive(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8);
    tick();
    n_cmp++; if (out_word !== 32'h008000EF || out_addr !== 32'hBFC0000C) begin n_fail++; $display("FAIL j_word: got %h@%h want 008000ef@bfc0000c", out_word, out_addr); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd12);
    tick();
    // A second bundle waits on the input while the output is stalled
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_word !== 32'h0020A623 || out_addr !== 32'hBFC00010) begin
        n_fail++; $display("FAIL s_hold%0d: got %b/%h@%h want 1/0020a623@bfc00010", i, out_valid, out_word, out_addr); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL s_ready%0d: got %b want 0", i, in_ready); end
      if (i < 2) tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL s_release_ready: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_word !== 32'h00500093 || out_addr !== 32'hBFC00014) begin n_fail++; $display("FAIL after_stall: got %h@%h want 00500093@bfc00014", out_word, out_addr); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_u_load();
    drive(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000);
    addr_load = 1'b1; addr_in = 32'h100;
    tick();
    addr_load = 1'b0; addr_in = 32'h0;
    n_cmp++; if (out_word !== 32'h123452B7 || out_addr !== 32'h100) begin n_fail++; $display("FAIL u_word: got %h@%h want 123452b7@00000100", out_word, out_addr); end
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    n_cmp++; if (out_addr !== 32'h104) begin n_fail++; $display("FAIL u_next_addr: got %h want 00000104", out_addr); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_range();
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h800);
    tick();
    in_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL range_valid: got %b want 0", out_valid); end
    n_cmp++; if (err_flag !== 1'b1 || err_count !== 8'd1) begin n_fail++; $display("FAIL range_err: got %b/%h want 1/01", err_flag, err_count); end
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_addr !== 32'h108) begin n_fail++; $display("FAIL range_addr: got %h want 00000108", out_addr); end
    err_base = 8'd1;
`else
    n_cmp++; if (out_valid !== 1'b1 || out_word !== 32'h80000093 || out_addr !== 32'h108) begin
      n_fail++; $display("FAIL trunc_word: got %b/%h@%h want 1/80000093@00000108", out_valid, out_word, out_addr); end
    n_cmp++; if (err_flag !== 1'b0 || err_count !== 8'd0) begin n_fail++; $display("FAIL trunc_err: got %b/%h want 0/00", err_flag, err_count); end
    err_base = 8'd0;
`endif
    tick();
  endtask

  task automatic test_reserved();
    drive(3'd6, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rsvd_valid: got %b want 0", out_valid); end
    n_cmp++; if (err_flag !== 1'b1 || err_count !== err_base + 8'd1) begin n_fail++; $display("FAIL rsvd_err: got %b/%h want 1/%h", err_flag, err_count, err_base + 8'd1); end
    drive(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0);
    repeat (300) tick();
    in_valid = 1'b0;
    n_cmp++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL err_saturate: got %h want ff", err_count); end
    tick();
  endtask

  task automatic test_reset_held();
    out_ready = 1'b0;
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL held_valid: got %b want 1", out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_word !== 32'h0) begin n_fail++; $display("FAIL rst_held_out: got %b/%h want 0/00000000", out_valid, out_word); end
    n_cmp++; if (out_addr !== 32'hBFC00000) begin n_fail++; $display("FAIL rst_held_addr: got %h want bfc00000", out_addr); end
    n_cmp++; if (err_count !== 8'd0 || err_flag !== 1'b0) begin n_fail++; $display("FAIL rst_held_err: got %b/%h want 0/00", err_flag, err_count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_held_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    fmt = 3'd0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;
    addr_load = 1'b0; addr_in = 32'd0; err_base = 8'd0;
    test_reset();
    test_i_then_r();
    test_b_j();
    test_stall();
    test_u_load();
    test_range();
    test_reserved();
    test_reset_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
